// File: rtl/ddr_port_arbiter_if.sv
// Burst command channel between the port arbiter and the AXI burst master.
// The arbiter side is the master modport; the AXI engine side is the slave.
interface ddr_port_arbiter_if #(
   parameter int ADDR_W = 30,
   parameter int LEN_W  = 8
) ();
   logic              burst_valid;
   logic              burst_ready;
   logic              burst_rw;
   logic [ADDR_W-1:0] burst_addr;
   logic [LEN_W-1:0]  burst_len;
   logic              burst_done;

   modport master (
      output burst_valid, burst_rw, burst_addr, burst_len,
      input  burst_ready, burst_done
   );

   modport slave (
      input  burst_valid, burst_rw, burst_addr, burst_len,
      output burst_ready, burst_done
   );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Two-port DDR burst arbiter: port0 priority with a starvation cap, one burst in flight.
// Ack/grant one cycle after request; command held until burst_ready; WAIT_DONE bounded by TIMEOUT.
module ddr_port_arbiter #(
   parameter int ADDR_W     = 30,
   parameter int LEN_W      = 8,
   parameter int MAX_CONSEC = 4,
   parameter int TIMEOUT    = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_rw,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [LEN_W-1:0]  p0_len,
   output logic              p0_ack,
   output logic              p0_done,
   input  logic              p1_req,
   input  logic              p1_rw,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [LEN_W-1:0]  p1_len,
   output logic              p1_ack,
   output logic              p1_done,
   ddr_port_arbiter_if.master bus,
   output logic [1:0]        grant,
   output logic              err_timeout,
   output logic              err_stray
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

   localparam logic [3:0]  MAXC     = 4'(MAX_CONSEC);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [1:0]        grant_d;
   logic [1:0]        ack_q, ack_d;
   logic [1:0]        done_q, done_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [3:0]        consec_q, consec_d;
   logic [15:0]       tmo_q, tmo_d;
   logic              err_to_d, err_st_d;
   logic              pick_p1;

   // port1 wins when port0 is quiet or port0 has used up its consecutive budget
   assign pick_p1 = p1_req && (!p0_req || (consec_q == MAXC));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant       <= '0;
         ack_q       <= '0;
         done_q      <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         consec_q    <= '0;
         tmo_q       <= '0;
         err_timeout <= 1'b0;
         err_stray   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant       <= grant_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         consec_q    <= consec_d;
         tmo_q       <= tmo_d;
         err_timeout <= err_to_d;
         err_stray   <= err_st_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (p0_req || p1_req) state_d = ISSUE;
         ISSUE:     if (bus.burst_ready) state_d = WAIT_DONE;
         WAIT_DONE: if (bus.burst_done || (tmo_q == TMO_LAST)) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d  = grant;
      ack_d    = '0;
      done_d   = '0;
      rw_d     = rw_q;
      addr_d   = addr_q;
      len_d    = len_q;
      consec_d = consec_q;
      tmo_d    = tmo_q;
      err_to_d = err_timeout;
      err_st_d = err_stray;
      case (state_q)
         IDLE: begin
            if (bus.burst_done) err_st_d = 1'b1;
            if (pick_p1) begin
               grant_d  = 2'b10;
               ack_d    = 2'b10;
               rw_d     = p1_rw;
               addr_d   = p1_addr;
               len_d    = p1_len;
               consec_d = '0;
            end else if (p0_req) begin
               grant_d  = 2'b01;
               ack_d    = 2'b01;
               rw_d     = p0_rw;
               addr_d   = p0_addr;
               len_d    = p0_len;
               consec_d = p1_req ? consec_q + 4'd1 : 4'd0;
            end
         end
         ISSUE: begin
            // a done here cannot belong to this command; flag it and keep going
            if (bus.burst_done) err_st_d = 1'b1;
            if (bus.burst_ready) tmo_d = '0;
         end
         WAIT_DONE: begin
            if (bus.burst_done) begin
               done_d  = grant;
               grant_d = '0;
            end else if (tmo_q == TMO_LAST) begin
               done_d   = grant;
               grant_d  = '0;
               err_to_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         default: ;
      endcase
   end

   assign p0_ack          = ack_q[0];
   assign p1_ack          = ack_q[1];
   assign p0_done         = done_q[0];
   assign p1_done         = done_q[1];
   assign bus.burst_valid = (state_q == ISSUE);
   assign bus.burst_rw    = rw_q;
   assign bus.burst_addr  = addr_q;
   assign bus.burst_len   = len_q;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: directed scenarios plus randomized bursts against
// a transaction-level model of arbitration order, latency and timeout.
module tb_ddr_port_arbiter;
   localparam int ADDR_W     = 30;
   localparam int LEN_W      = 8;
   localparam int MAX_CONSEC = 4;
   localparam int TIMEOUT    = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              p0_req, p0_rw, p0_ack, p0_done;
   logic              p1_req, p1_rw, p1_ack, p1_done;
   logic [ADDR_W-1:0] p0_addr, p1_addr;
   logic [LEN_W-1:0]  p0_len, p1_len;
   logic [1:0]        grant;
   logic              err_timeout, err_stray;

   int checks = 0;
   int errors = 0;
   int both_cnt = 0;

   ddr_port_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   ddr_port_arbiter #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_CONSEC(MAX_CONSEC), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_len(p0_len),
      .p0_ack(p0_ack), .p0_done(p0_done),
      .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_len(p1_len),
      .p1_ack(p1_ack), .p1_done(p1_done),
      .bus(bus),
      .grant(grant), .err_timeout(err_timeout), .err_stray(err_stray)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   task automatic do_reset();
      rst = 1'b1;
      p0_req = 0; p0_rw = 0; p0_addr = '0; p0_len = '0;
      p1_req = 0; p1_rw = 0; p1_addr = '0; p1_len = '0;
      bus.burst_ready = 0; bus.burst_done = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic new_req0();
      p0_req = 1; p0_rw = 1'($urandom()); p0_addr = ADDR_W'($urandom()); p0_len = LEN_W'($urandom());
   endtask

   task automatic new_req1();
      p1_req = 1; p1_rw = 1'($urandom()); p1_addr = ADDR_W'($urandom()); p1_len = LEN_W'($urandom());
   endtask

   // steps until an ack is seen (bounded); returns on the negedge where it is visible
   task automatic wait_ack(output logic [1:0] who, output int lat);
      who = 2'b00;
      lat = 0;
      while (lat < 30) begin
         @(negedge clk);
         lat++;
         if ((p0_ack & p1_ack) | (p0_done & p1_done)) both_cnt++;
         if (p0_ack | p1_ack) begin
            who = {p1_ack, p0_ack};
            break;
         end
      end
   endtask

   // acts as the AXI engine from the ack cycle (t=0) until the done pulse
   task automatic serve(input int rdy_wait, input int done_wait, output int vld_cycles,
                        output logic stable, output logic [1:0] done_who,
                        output int done_cyc, output int acks_extra);
      logic              f_rw;
      logic [ADDR_W-1:0] f_addr;
      logic [LEN_W-1:0]  f_len;
      f_rw = bus.burst_rw; f_addr = bus.burst_addr; f_len = bus.burst_len;
      vld_cycles = 0; stable = 1; done_who = 2'b00; done_cyc = -1; acks_extra = 0;
      for (int t = 0; t < 60; t++) begin
         if ((p0_ack & p1_ack) | (p0_done & p1_done)) both_cnt++;
         if (t > 0 && (p0_ack | p1_ack)) acks_extra++;
         if (bus.burst_valid) begin
            vld_cycles++;
            if (bus.burst_rw !== f_rw || bus.burst_addr !== f_addr || bus.burst_len !== f_len)
               stable = 0;
         end
         if (p0_done | p1_done) begin
            done_who = {p1_done, p0_done};
            done_cyc = t;
            break;
         end
         bus.burst_ready = (t >= rdy_wait);
         bus.burst_done  = (t == rdy_wait + 1 + done_wait);
         @(negedge clk);
      end
      bus.burst_ready = 0;
      bus.burst_done  = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.burst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.burst_valid); end
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
      checks++; if ({p0_ack, p1_ack, p0_done, p1_done} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {p0_ack, p1_ack, p0_done, p1_done}); end
      checks++; if ({bus.burst_rw, bus.burst_addr, bus.burst_len} !== '0) begin errors++; $display("FAIL reset_fields got %h/%h/%h exp 0", bus.burst_rw, bus.burst_addr, bus.burst_len); end
      checks++; if ({err_timeout, err_stray} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b exp 00", {err_timeout, err_stray}); end
   endtask

   task automatic test_basic();
      do_reset();
      p0_req = 1; p0_rw = 0; p0_addr = ADDR_W'('h100); p0_len = LEN_W'(15); bus.burst_ready = 1;
      @(negedge clk);
      p0_req = 0;
      checks++; if ({p0_ack, p1_ack, bus.burst_valid} !== 3'b101) begin errors++; $display("FAIL basic_ack got ack0=%b ack1=%b vld=%b exp 1 0 1", p0_ack, p1_ack, bus.burst_valid); end
      checks++; if (bus.burst_addr !== ADDR_W'('h100) || bus.burst_len !== LEN_W'(15) || bus.burst_rw !== 1'b0) begin errors++; $display("FAIL basic_fields got %h/%0d/%b exp 100/15/0", bus.burst_addr, bus.burst_len, bus.burst_rw); end
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL basic_grant got %b exp 01", grant); end
      @(negedge clk);
      bus.burst_ready = 0;
      checks++; if (bus.burst_valid !== 1'b0 || p0_ack !== 1'b0) begin errors++; $display("FAIL basic_accept got vld=%b ack=%b exp 0 0", bus.burst_valid, p0_ack); end
      repeat (8) @(negedge clk);
      bus.burst_done = 1;
      @(negedge clk);
      bus.burst_done = 0;
      checks++; if ({p0_done, p1_done, grant} !== 4'b1000) begin errors++; $display("FAIL basic_done got done0=%b done1=%b grant=%b exp 1 0 00", p0_done, p1_done, grant); end
      @(negedge clk);
      checks++; if (p0_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", p0_done); end
   endtask

   task automatic test_fairness();
      logic [1:0] who, dwho, exp_win;
      int lat, vc, dc, ax, c;
      logic st;
      do_reset();
      c = 0;
      new_req0(); new_req1();
      for (int i = 0; i < 10; i++) begin
         exp_win = (c == MAX_CONSEC) ? 2'b10 : 2'b01;
         c = (exp_win == 2'b10) ? 0 : c + 1;
         wait_ack(who, lat);
         checks++; if (who !== exp_win || lat != 1) begin errors++; $display("FAIL fair_grant[%0d] got %b lat %0d exp %b lat 1", i, who, lat, exp_win); end
         serve(0, 0, vc, st, dwho, dc, ax);
         checks++; if (dwho !== exp_win || dc != 2) begin errors++; $display("FAIL fair_done[%0d] got %b at %0d exp %b at 2", i, dwho, dc, exp_win); end
      end
      p0_req = 0; p1_req = 0;
   endtask

   task automatic test_backpressure();
      logic [1:0] who, dwho;
      int lat, vc, dc, ax;
      logic st;
      do_reset();
      new_req1();
      wait_ack(who, lat);
      checks++; if (who !== 2'b10 || lat != 1) begin errors++; $display("FAIL bp_ack got %b lat %0d exp 10 lat 1", who, lat); end
      serve(5, 2, vc, st, dwho, dc, ax);
      p1_req = 0;
      checks++; if (vc != 6 || st !== 1'b1) begin errors++; $display("FAIL bp_valid got %0d cycles stable=%b exp 6 stable=1", vc, st); end
      checks++; if (ax != 0) begin errors++; $display("FAIL bp_single_ack got %0d extra acks exp 0", ax); end
      checks++; if (dwho !== 2'b10 || dc != 9) begin errors++; $display("FAIL bp_done got %b at %0d exp 10 at 9", dwho, dc); end
   endtask

   task automatic test_stray();
      logic [1:0] who;
      int lat;
      do_reset();
      bus.burst_done = 1;
      @(negedge clk);
      bus.burst_done = 0;
      checks++; if (err_stray !== 1'b1) begin errors++; $display("FAIL stray_idle_flag got %b exp 1", err_stray); end
      checks++; if ({p0_done, p1_done, grant, bus.burst_valid} !== 5'b0) begin errors++; $display("FAIL stray_idle_quiet got %b exp 00000", {p0_done, p1_done, grant, bus.burst_valid}); end
      new_req0();
      wait_ack(who, lat);
      p0_req = 0;
      checks++; if (who !== 2'b01 || lat != 1) begin errors++; $display("FAIL stray_then_req got %b lat %0d exp 01 lat 1", who, lat); end
      do_reset();
      checks++; if (err_stray !== 1'b0) begin errors++; $display("FAIL stray_cleared got %b exp 0", err_stray); end
      new_req0();
      wait_ack(who, lat);
      p0_req = 0;
      bus.burst_ready = 1; bus.burst_done = 1;
      @(negedge clk);
      bus.burst_ready = 0; bus.burst_done = 0;
      checks++; if ({bus.burst_valid, p0_done, err_stray} !== 3'b001) begin errors++; $display("FAIL stray_issue got vld=%b done=%b stray=%b exp 0 0 1", bus.burst_valid, p0_done, err_stray); end
      bus.burst_done = 1;
      @(negedge clk);
      bus.burst_done = 0;
      checks++; if (p0_done !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL stray_issue_done got done=%b to=%b exp 1 0", p0_done, err_timeout); end
   endtask

   task automatic test_timeout();
      logic [1:0] who, dwho;
      int lat, vc, dc, ax;
      logic st;
      do_reset();
      new_req0();
      wait_ack(who, lat);
      p0_req = 0;
      serve(0, 1000, vc, st, dwho, dc, ax);
      checks++; if (dwho !== 2'b01 || dc != 1 + TIMEOUT) begin errors++; $display("FAIL tmo_done got %b at %0d exp 01 at %0d", dwho, dc, 1 + TIMEOUT); end
      checks++; if (err_timeout !== 1'b1 || grant !== 2'b00) begin errors++; $display("FAIL tmo_flag got to=%b grant=%b exp 1 00", err_timeout, grant); end
      new_req1();
      wait_ack(who, lat);
      p1_req = 0;
      checks++; if (who !== 2'b10 || lat != 1 || err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_idle got %b lat %0d to=%b exp 10 lat 1 to=1", who, lat, err_timeout); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] who, dwho;
      int lat, vc, dc, ax, seen;
      logic st;
      do_reset();
      new_req0();
      wait_ack(who, lat);
      p0_req = 0;
      bus.burst_ready = 1;
      repeat (3) @(negedge clk);
      bus.burst_ready = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
      checks++; if ({bus.burst_valid, grant, p0_done, p1_done, p0_ack, p1_ack, err_timeout, err_stray} !== 9'b0) begin errors++; $display("FAIL rstmid_outputs got %b exp 0", {bus.burst_valid, grant, p0_done, p1_done, p0_ack, p1_ack, err_timeout, err_stray}); end
      checks++; if (bus.burst_addr !== '0 || bus.burst_len !== '0) begin errors++; $display("FAIL rstmid_fields got %h/%h exp 0/0", bus.burst_addr, bus.burst_len); end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (p0_done | p1_done) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses exp 0", seen); end
      new_req1();
      wait_ack(who, lat);
      p1_req = 0;
      serve(1, 3, vc, st, dwho, dc, ax);
      checks++; if (who !== 2'b10 || lat != 1 || dwho !== 2'b10 || dc != 6) begin errors++; $display("FAIL rstmid_after got ack %b lat %0d done %b at %0d exp 10 1 10 6", who, lat, dwho, dc); end
   endtask

   task automatic test_random();
      logic [1:0] who, dwho, win;
      logic st, exp_to, e_rw;
      logic [ADDR_W-1:0] e_addr;
      logic [LEN_W-1:0]  e_len;
      int lat, vc, dc, ax, c, rw_n, dw_n, exp_dc;
      do_reset();
      c = 0; exp_to = 0; both_cnt = 0;
      for (int n = 0; n < 40; n++) begin
         if (!p0_req && !p1_req) begin
            case ($urandom_range(0, 2))
               0:       new_req0();
               1:       new_req1();
               default: begin new_req0(); new_req1(); end
            endcase
         end
         // port0 first, unless it has had MAX_CONSEC grants in a row over a waiting port1
         win = (p1_req && (!p0_req || c == MAX_CONSEC)) ? 2'b10 : 2'b01;
         c = (win == 2'b10) ? 0 : (p1_req ? c + 1 : 0);
         e_rw   = (win == 2'b10) ? p1_rw : p0_rw;
         e_addr = (win == 2'b10) ? p1_addr : p0_addr;
         e_len  = (win == 2'b10) ? p1_len : p0_len;
         wait_ack(who, lat);
         checks++; if (who !== win || lat != 1) begin errors++; $display("FAIL rnd_ack[%0d] got %b lat %0d exp %b lat 1", n, who, lat, win); end
         checks++; if (bus.burst_rw !== e_rw || bus.burst_addr !== e_addr || bus.burst_len !== e_len || grant !== win) begin errors++; $display("FAIL rnd_cmd[%0d] got %b/%h/%h g%b exp %b/%h/%h g%b", n, bus.burst_rw, bus.burst_addr, bus.burst_len, grant, e_rw, e_addr, e_len, win); end
         if (win == 2'b01) p0_req = 0; else p1_req = 0;
         rw_n = $urandom_range(0, 3);
         dw_n = $urandom_range(0, 18);
         exp_dc = rw_n + 1 + ((dw_n > TIMEOUT - 1) ? TIMEOUT - 1 : dw_n) + 1;
         if (dw_n > TIMEOUT - 1) exp_to = 1;
         serve(rw_n, dw_n, vc, st, dwho, dc, ax);
         checks++; if (vc != rw_n + 1 || st !== 1'b1 || ax != 0) begin errors++; $display("FAIL rnd_issue[%0d] got vld %0d st %b xack %0d exp %0d 1 0", n, vc, st, ax, rw_n + 1); end
         checks++; if (dwho !== win || dc != exp_dc) begin errors++; $display("FAIL rnd_done[%0d] got %b at %0d exp %b at %0d", n, dwho, dc, win, exp_dc); end
         checks++; if (err_timeout !== exp_to || err_stray !== 1'b0) begin errors++; $display("FAIL rnd_errs[%0d] got to=%b stray=%b exp %b 0", n, err_timeout, err_stray, exp_to); end
         if ($urandom_range(0, 1) == 1) begin
            if (win == 2'b01) new_req0(); else new_req1();
         end
      end
      checks++; if (both_cnt != 0) begin errors++; $display("FAIL rnd_exclusive got %0d dual-port pulses exp 0", both_cnt); end
      p0_req = 0; p1_req = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fairness();
      test_backpressure();
      test_stray();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, burst address width.
REQ-002 SHALL have parameter LEN_W, default 8, AXI burst length width (beats-1).
REQ-003 SHALL have parameter MAX_CONSEC, default 4, max back-to-back port0 grants while port1 waits (range 1..15).
REQ-004 SHALL have parameter TIMEOUT, default 4096, max WAIT_DONE cycles before abort (16-bit counter).
REQ-005 clk  in  1  single clock (AXI/MIG user clock domain); all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pN_req  in  1  (N=0,1) port N burst request; held with pN_rw/pN_addr/pN_len until pN_ack.
REQ-008 pN_rw  in  1  0 = write burst, 1 = read burst.
REQ-009 pN_addr  in  ADDR_W  burst start byte address.
REQ-010 pN_len  in  LEN_W  burst length minus one.
REQ-011 pN_ack  out  1  one-cycle pulse: request latched.
REQ-012 pN_done  out  1  one-cycle pulse: port N burst completed.
REQ-013 burst_valid  out  1  command to AXI master valid.
REQ-014 burst_ready  in  1  AXI master accepts command.
REQ-015 burst_rw / burst_addr / burst_len  out  1 / ADDR_W / LEN_W  latched command fields.
REQ-016 burst_done  in  1  one-cycle pulse from AXI master: burst finished (last beat / BRESP).
REQ-017 grant  out  2  one-hot owner of current burst; 0 when idle.
REQ-018 err_timeout / err_stray  out  1 / 1  sticky error flags.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT_DONE -> IDLE.
REQ-020 IDLE: if any pN_req, choose winner, latch its rw/addr/len into burst_* and set grant, pulse pN_ack, enter ISSUE -- all visible the cycle after request sampled (latency 1).
REQ-021 ISSUE: burst_valid=1, command fields stable; on burst_ready=1 drop burst_valid next cycle, enter WAIT_DONE.
REQ-022 WAIT_DONE: on burst_done=1 pulse pN_done of granted port next cycle, clear grant, enter IDLE; new arbitration possible the cycle after that.
REQ-023 Arbitration: port0 has priority; port1 wins if port0 idle, or if both request and consec0 == MAX_CONSEC.
REQ-024 consec0 (4-bit) SHALL increment on port0 grant while p1_req=1, clear on port1 grant or on port0 grant with p1_req=0; never exceeds MAX_CONSEC.
REQ-025 Requests arriving outside IDLE SHALL be held off (no ack) until next IDLE.
REQ-026 burst_done in IDLE or ISSUE SHALL be ignored except setting err_stray=1.
REQ-027 burst_done and burst_ready same cycle in ISSUE: accept command, ignore done, set err_stray.
REQ-028 Timeout counter SHALL clear on WAIT_DONE entry, increment each WAIT_DONE cycle; reaching TIMEOUT-1 without burst_done: set err_timeout, pulse granted pN_done, enter IDLE.
REQ-029 burst_addr/len SHALL pass unmodified; no alignment or 4 KB boundary check.
REQ-030 pN_ack and pN_done SHALL never be asserted for both ports in one cycle.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, burst_valid=0, burst_rw/addr/len=0, grant=0, pN_ack=0, pN_done=0, consec0=0, timeout counter=0, err_timeout=0, err_stray=0.
REQ-032 Reset mid-burst SHALL abort silently: no pN_done pulse, in-flight command dropped.
REQ-033 Error flags clear only by rst.

Verification
REQ-034 p0_req=1,rw=0,addr=0x100,len=15 at cycle 0, ready=1 -> p0_ack and burst_valid cycle 1, burst_addr=0x100, burst_len=15; done at cycle 10 -> p0_done cycle 11, grant=0.
REQ-035 p0_req and p1_req held continuously, immediate ready/done -> grant sequence 0,0,0,0,1,0,0,0,0,1 (MAX_CONSEC=4).
REQ-036 p1 alone, burst_ready low 5 cycles -> burst_valid held 5 cycles with stable fields, p1_ack only once.
REQ-037 burst_done pulsed while IDLE -> err_stray=1, no pN_done, state unchanged.
REQ-038 TIMEOUT=16, no burst_done -> err_timeout=1 and pN_done after 16 WAIT_DONE cycles, FSM in IDLE.
REQ-039 rst asserted in WAIT_DONE -> next cycle all outputs zero, no pN_done; new request served normally afterwards.
